// File: rtl/i3c_ctrl_pkg.sv
// i3c_ctrl_pkg
//   Shared types and defaults for the I3C controller and its bus-monitor
//   front end.
//   bus_event_t    : one-cycle bus event flags handed to the controller FSM
//   T_FILT_DEFAULT : default glitch-filter length (clk cycles beyond one)
//   T_IDLE_DEFAULT : default bus-free time in clk cycles
package i3c_ctrl_pkg;

  localparam int unsigned T_FILT_DEFAULT = 4;
  localparam int unsigned T_IDLE_DEFAULT = 200;

  typedef struct packed {
    logic start;
    logic rstart;
    logic stop;
    logic scl_rise;
    logic scl_fall;
    logic bit_valid;
  } bus_event_t;

  localparam bus_event_t BUS_EVENT_NONE = '0;

endpackage

// File: rtl/i3c_line_filter.sv
// i3c_line_filter
//   Synchroniser followed by a persistence glitch filter for one open-drain
//   bus line. The filtered output only follows the synchronised input once
//   it has disagreed for t_filt_i+1 consecutive clocks.
// Ports
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset (line idles high)
//   raw_i    in  raw pad value
//   t_filt_i in  filter length
//   filt_o   out filtered line value (registered)
module i3c_line_filter
  import i3c_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              raw_i,
  input  logic [FILT_W-1:0] t_filt_i,
  output logic              filt_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced_s;

  assign synced_s = sync_q[SYNC_STAGES-1];

  // Next-state: shift the synchroniser, count disagreement, toggle when it persists
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    filt_d = filt_q;
    cnt_d  = '0;
    if (synced_s != filt_q) begin
      // >= so that lowering t_filt_i mid-count acts on the very next clock
      if (cnt_q >= t_filt_i) begin
        filt_d = ~filt_q;
        cnt_d  = '0;
      end else begin
        filt_d = filt_q;
        cnt_d  = cnt_q + 1'b1;
      end
    end else begin
      filt_d = filt_q;
      cnt_d  = '0;
    end
  end

  // State registers; bus lines are pulled up, so everything resets high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b1}};
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/i3c_bus_monitor.sv
// i3c_bus_monitor
//   Front end for i3c_ctrl: filters SDA/SCL, detects START / Repeated START /
//   STOP and SCL edges, samples data bits, tracks busy and bus-idle state.
//   All event outputs are registered single-cycle pulses.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   enable_i              monitor enable (filters run regardless)
//   sda_i, scl_i          raw pad inputs
//   t_filt_i, t_idle_i    filter length, bus-free time
//   sda_f_o, scl_f_o      filtered lines
//   scl_rise_o/fall_o     SCL edge pulses
//   start_o/rstart_o      START while idle / while busy
//   stop_o                STOP pulse
//   bit_valid_o, bit_o    sampled data bit strobe and held value
//   bus_busy_o            between START and STOP
//   bus_idle_o            lines high and not busy for t_idle_i cycles
module i3c_bus_monitor
  import i3c_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4,
  parameter int unsigned IDLE_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              sda_i,
  input  logic              scl_i,
  input  logic [FILT_W-1:0] t_filt_i,
  input  logic [IDLE_W-1:0] t_idle_i,
  output logic              sda_f_o,
  output logic              scl_f_o,
  output logic              scl_rise_o,
  output logic              scl_fall_o,
  output logic              start_o,
  output logic              rstart_o,
  output logic              stop_o,
  output logic              bit_valid_o,
  output logic              bit_o,
  output logic              bus_busy_o,
  output logic              bus_idle_o
);

  logic              sda_f, scl_f;
  logic              sda_prev_q, scl_prev_q;
  bus_event_t        evt_q, evt_d;
  logic              bit_q, bit_d;
  logic              busy_q, busy_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              idle_q, idle_d;
  logic              sda_fell_s, sda_rose_s, scl_high_s, scl_rose_s, scl_fell_s;

  i3c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .raw_i(sda_i), .t_filt_i(t_filt_i), .filt_o(sda_f)
  );

  i3c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .raw_i(scl_i), .t_filt_i(t_filt_i), .filt_o(scl_f)
  );

  // Requiring SCL high both now and before rejects SDA/SCL moving together
  assign sda_fell_s = sda_prev_q & ~sda_f;
  assign sda_rose_s = ~sda_prev_q & sda_f;
  assign scl_high_s = scl_prev_q & scl_f;
  assign scl_rose_s = ~scl_prev_q & scl_f;
  assign scl_fell_s = scl_prev_q & ~scl_f;

  // Event decode, busy tracking and bus-free counter
  always_comb begin
    evt_d      = BUS_EVENT_NONE;
    bit_d      = bit_q;
    busy_d     = 1'b0;
    idle_cnt_d = '0;
    idle_d     = 1'b0;
    if (enable_i) begin
      evt_d.start     = sda_fell_s & scl_high_s & ~busy_q;
      evt_d.rstart    = sda_fell_s & scl_high_s & busy_q;
      evt_d.stop      = sda_rose_s & scl_high_s;
      evt_d.scl_rise  = scl_rose_s;
      evt_d.scl_fall  = scl_fell_s;
      evt_d.bit_valid = scl_rose_s & busy_q;
      if (scl_rose_s & busy_q) begin
        bit_d = sda_f;
      end else begin
        bit_d = bit_q;
      end
      if (sda_fell_s & scl_high_s) begin
        busy_d = 1'b1;
      end else if (sda_rose_s & scl_high_s) begin
        busy_d = 1'b0;
      end else begin
        busy_d = busy_q;
      end
      if (~busy_q & scl_f & sda_f) begin
        if (idle_cnt_q >= t_idle_i) begin
          idle_cnt_d = t_idle_i;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        idle_d = (idle_cnt_d == t_idle_i);
      end else begin
        idle_cnt_d = '0;
        idle_d     = 1'b0;
      end
    end else begin
      // Disabled: history keeps tracking so re-enable cannot see a stale edge
      evt_d      = BUS_EVENT_NONE;
      bit_d      = bit_q;
      busy_d     = 1'b0;
      idle_cnt_d = '0;
      idle_d     = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_prev_q <= 1'b1;
      scl_prev_q <= 1'b1;
      evt_q      <= BUS_EVENT_NONE;
      bit_q      <= 1'b0;
      busy_q     <= 1'b0;
      idle_cnt_q <= '0;
      idle_q     <= 1'b0;
    end else begin
      sda_prev_q <= sda_f;
      scl_prev_q <= scl_f;
      evt_q      <= evt_d;
      bit_q      <= bit_d;
      busy_q     <= busy_d;
      idle_cnt_q <= idle_cnt_d;
      idle_q     <= idle_d;
    end
  end

  assign sda_f_o     = sda_f;
  assign scl_f_o     = scl_f;
  assign scl_rise_o  = evt_q.scl_rise;
  assign scl_fall_o  = evt_q.scl_fall;
  assign start_o     = evt_q.start;
  assign rstart_o    = evt_q.rstart;
  assign stop_o      = evt_q.stop;
  assign bit_valid_o = evt_q.bit_valid;
  assign bit_o       = bit_q;
  assign bus_busy_o  = busy_q;
  assign bus_idle_o  = idle_q;

endmodule

// File: tb/tb_i3c_bus_monitor.sv
// tb_i3c_bus_monitor
//   Directed bus scenarios plus randomized pin activity, compared every cycle
//   against a behavioural model of the monitor kept in this file.
module tb_i3c_bus_monitor;

  localparam int SYNC = 2;
  localparam int H    = 8;   // pin hold time for bus phases
  localparam logic [10:0] RST_VEC = 11'b110_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        sda_pin = 1'b1;
  logic        scl_pin = 1'b1;
  logic [3:0]  t_filt = 4'd2;
  logic [15:0] t_idle = 16'd20;
  logic sda_f_o, scl_f_o, scl_rise_o, scl_fall_o, start_o, rstart_o, stop_o;
  logic bit_valid_o, bit_o, bus_busy_o, bus_idle_o;

  i3c_bus_monitor dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .sda_i(sda_pin), .scl_i(scl_pin),
    .t_filt_i(t_filt), .t_idle_i(t_idle), .sda_f_o(sda_f_o), .scl_f_o(scl_f_o),
    .scl_rise_o(scl_rise_o), .scl_fall_o(scl_fall_o), .start_o(start_o),
    .rstart_o(rstart_o), .stop_o(stop_o), .bit_valid_o(bit_valid_o), .bit_o(bit_o),
    .bus_busy_o(bus_busy_o), .bus_idle_o(bus_idle_o)
  );

  always #5 clk = ~clk;

  wire [10:0] dut_vec = {sda_f_o, scl_f_o, scl_rise_o, scl_fall_o, start_o, rstart_o,
                         stop_o, bit_valid_o, bit_o, bus_busy_o, bus_idle_o};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  bit q_sda[$], q_scl[$];                 // pin samples still inside the synchroniser
  bit m_fs, m_fc, m_fs_prev, m_fc_prev;   // filtered lines, now and one clock ago
  int run_s, run_c;                       // consecutive clocks of disagreement
  bit m_rise, m_fall, m_start, m_rstart, m_stop, m_bitv, m_bit, m_busy, m_idle;
  int m_icnt;                             // clocks the bus has been free

  function automatic void model_reset();
    q_sda.delete(); q_scl.delete();
    for (int i = 0; i < SYNC; i++) begin q_sda.push_back(1'b1); q_scl.push_back(1'b1); end
    m_fs = 1; m_fc = 1; m_fs_prev = 1; m_fc_prev = 1; run_s = 0; run_c = 0;
    m_rise = 0; m_fall = 0; m_start = 0; m_rstart = 0; m_stop = 0; m_bitv = 0;
    m_bit = 0; m_busy = 0; m_idle = 0; m_icnt = 0;
  endfunction

  function automatic void model_step(input bit ps, input bit pc, input bit en, input int tf, input int ti);
    bit in_s, in_c, busy_old, both_hi;
    in_s = q_sda.pop_front(); q_sda.push_back(ps);
    in_c = q_scl.pop_front(); q_scl.push_back(pc);
    busy_old = m_busy;
    both_hi  = m_fc && m_fc_prev;
    m_rise = 0; m_fall = 0; m_start = 0; m_rstart = 0; m_stop = 0; m_bitv = 0;
    if (en) begin
      if (m_fs_prev && !m_fs && both_hi) begin
        if (busy_old) m_rstart = 1; else m_start = 1;
        m_busy = 1;
      end
      if (!m_fs_prev && m_fs && both_hi) begin m_stop = 1; m_busy = 0; end
      m_rise = !m_fc_prev && m_fc;
      m_fall = m_fc_prev && !m_fc;
      if (m_rise && busy_old) begin m_bitv = 1; m_bit = m_fs; end
      if (!busy_old && m_fc && m_fs) begin
        m_icnt = (m_icnt + 1 > ti) ? ti : m_icnt + 1;
        m_idle = (m_icnt == ti);
      end else begin
        m_icnt = 0; m_idle = 0;
      end
    end else begin
      m_busy = 0; m_icnt = 0; m_idle = 0;
    end
    m_fs_prev = m_fs; m_fc_prev = m_fc;
    // a line change is accepted once it has persisted tf+1 clocks
    if (in_s != m_fs) begin run_s++; if (run_s > tf) begin m_fs = ~m_fs; run_s = 0; end end
    else run_s = 0;
    if (in_c != m_fc) begin run_c++; if (run_c > tf) begin m_fc = ~m_fc; run_c = 0; end end
    else run_c = 0;
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_fs, m_fc, m_rise, m_fall, m_start, m_rstart, m_stop, m_bitv, m_bit, m_busy, m_idle};
  endfunction

  // ---------------- per-cycle checker and event log ----------------
  int n_start = 0, n_rstart = 0, n_stop = 0, n_bits = 0, n_scl = 0;
  int last_start_cyc = 0, last_stop_cyc = 0, idle_rise_cyc = 0;
  logic [7:0] bits_sr = 8'h00;
  logic idle_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      check_eq("cycle_outputs", {21'd0, dut_vec}, {21'd0, model_vec()});
      if (start_o) begin n_start++; last_start_cyc = cyc; end
      if (rstart_o) n_rstart++;
      if (stop_o) begin n_stop++; last_stop_cyc = cyc; end
      if (bit_valid_o) begin n_bits++; bits_sr = {bits_sr[6:0], bit_o}; end
      if (scl_rise_o || scl_fall_o) n_scl++;
      if (bus_idle_o && !idle_prev) idle_rise_cyc = cyc;
      idle_prev = bus_idle_o;
      if (rst_n) model_step(sda_pin, scl_pin, enable, int'(t_filt), int'(t_idle));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_tx(input logic b);
    scl_pin = 1'b0; tick(H);
    sda_pin = b;    tick(H);
    scl_pin = 1'b1; tick(H);
  endtask

  task automatic start_tx();
    if (!(sda_pin && scl_pin)) begin
      scl_pin = 1'b0; tick(H);
      sda_pin = 1'b1; tick(H);
      scl_pin = 1'b1; tick(H);
    end
    sda_pin = 1'b0; tick(H);
  endtask

  task automatic stop_tx();
    scl_pin = 1'b0; tick(H);
    sda_pin = 1'b0; tick(H);
    scl_pin = 1'b1; tick(H);
    sda_pin = 1'b1; tick(H);
  endtask

  int s0, r0, p0, b0, c0, e0;
  logic [7:0] byte_v;

  initial begin
    tick(3);
    check_eq("reset_outputs", {21'd0, dut_vec}, {21'd0, RST_VEC});
    rst_n = 1'b1;
    tick(25);
    check_eq("idle_from_reset", {31'd0, bus_idle_o}, 32'd1);

    // SDA glitch shorter than the filter
    s0 = n_start;
    sda_pin = 1'b0; tick(2); sda_pin = 1'b1; tick(12);
    check_eq("glitch_no_start", n_start - s0, 0);

    // START latency from pin edge
    c0 = cyc; sda_pin = 1'b0; tick(10);
    check_eq("start_count", n_start - s0, 1);
    check_eq("start_latency", last_start_cyc - c0, 6);
    check_eq("busy_after_start", {31'd0, bus_busy_o}, 32'd1);

    // data byte 0xA5 MSB-first then STOP
    byte_v = 8'hA5; b0 = n_bits; e0 = n_stop;
    for (int i = 7; i >= 0; i--) bit_tx(byte_v[i]);
    check_eq("byte_bit_count", n_bits - b0, 8);
    check_eq("byte_value", {24'd0, bits_sr}, {24'd0, byte_v});
    check_eq("busy_in_byte", {31'd0, bus_busy_o}, 32'd1);
    stop_tx();
    check_eq("stop_count", n_stop - e0, 1);
    check_eq("busy_after_stop", {31'd0, bus_busy_o}, 32'd0);
    tick(30);
    check_eq("idle_delay", idle_rise_cyc - last_stop_cyc, 20);

    // Repeated START
    start_tx(); bit_tx(1'b1); bit_tx(1'b0); bit_tx(1'b1); bit_tx(1'b1);
    s0 = n_start; r0 = n_rstart;
    start_tx();
    check_eq("rstart_count", n_rstart - r0, 1);
    check_eq("rstart_no_start", n_start - s0, 0);
    check_eq("busy_after_rstart", {31'd0, bus_busy_o}, 32'd1);
    stop_tx();

    // SCL dip before the bus-free time expires restarts the count
    tick(4);
    scl_pin = 1'b0; tick(6); scl_pin = 1'b1; tick(40);
    check_eq("idle_restarted", {31'd0, (idle_rise_cyc - last_stop_cyc) > 20}, 32'd1);
    check_eq("idle_after_dip", {31'd0, bus_idle_o}, 32'd1);

    // both lines falling together is not a START
    s0 = n_start; r0 = n_rstart; e0 = n_stop;
    sda_pin = 1'b0; scl_pin = 1'b0; tick(H);
    sda_pin = 1'b1; scl_pin = 1'b1; tick(H);
    check_eq("simul_no_start", (n_start - s0) + (n_rstart - r0) + (n_stop - e0), 0);
    tick(30);

    // disable mid-transfer, re-enable mid-byte
    start_tx(); bit_tx(1'b1); bit_tx(1'b0); bit_tx(1'b1);
    enable = 1'b0;
    p0 = n_start + n_rstart + n_stop + n_bits + n_scl;
    bit_tx(1'b1); bit_tx(1'b0);
    check_eq("disabled_no_pulses", n_start + n_rstart + n_stop + n_bits + n_scl - p0, 0);
    check_eq("disabled_busy", {31'd0, bus_busy_o}, 32'd0);
    enable = 1'b1;
    p0 = n_start + n_rstart + n_stop + n_bits;
    bit_tx(1'b1); bit_tx(1'b1); bit_tx(1'b0);
    check_eq("reenable_quiet", n_start + n_rstart + n_stop + n_bits - p0, 0);
    s0 = n_start;
    start_tx();
    check_eq("reenable_start", n_start - s0, 1);
    bit_tx(1'b0); bit_tx(1'b1);
    stop_tx();
    tick(10);

    // asynchronous reset mid-byte
    start_tx(); bit_tx(1'b1); bit_tx(1'b0); bit_tx(1'b1);
    rst_n = 1'b0; #1;
    check_eq("async_reset", {21'd0, dut_vec}, {21'd0, RST_VEC});
    tick(3);
    rst_n = 1'b1; sda_pin = 1'b1; scl_pin = 1'b1;
    tick(30);

    // randomized pin activity, filter/idle settings and enable
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0) t_filt = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) t_idle = 16'($urandom_range(0, 15));
      sda_pin = 1'($urandom_range(0, 1));
      scl_pin = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 6));
    end
    enable = 1'b1; sda_pin = 1'b1; scl_pin = 1'b1;
    tick(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
